led_multi_blinker: RTL and testbench

//  - Parametrised N-channel LED driver. Each channel has a run-time period, mode and duty.
//  - Replaces per-LED fixed-period counter instances at board top level.
//  - One config port programs any channel; the update is applied glitch-free at that channel's period boundary.

---
 rtl/led_pkg.sv | 21 ++
 rtl/led_chan.sv | 79 +++++++
 rtl/led_multi_blinker.sv | 84 ++++++++
 tb/tb_led_multi_blinker.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// ============================================================================
// led_pkg: shared mode encodings and channel-index width helper for the
//          multi-channel LED blinker.  Revision 1.0
// ============================================================================
`default_nettype none

package led_pkg;

    localparam logic [1:0] MODE_TOGGLE = 2'b00;
    localparam logic [1:0] MODE_PWM    = 2'b01;
    localparam logic [1:0] MODE_OFF    = 2'b10;
    localparam logic [1:0] MODE_ON     = 2'b11;

    // A single channel still needs a 1-bit select port.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/led_chan.sv
// ============================================================================
// led_chan: one LED channel -- period counter, wrap strobe and mode-driven LED
//           output; new settings load on an apply strobe.  Revision 1.0
// ============================================================================
`default_nettype none

module led_chan
    import led_pkg::*;
#(
    parameter int CNT_W   = 26,
    parameter int DEF_MAX = 49_999
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             apply,
    input  logic [1:0]       new_mode,
    input  logic [CNT_W-1:0] new_max,
    input  logic [CNT_W-1:0] new_duty,
    output logic             wrap,
    output logic             led,
    output logic             tick
);

    localparam logic [CNT_W-1:0] RST_MAX  = CNT_W'(DEF_MAX);
    localparam logic [CNT_W-1:0] RST_DUTY = CNT_W'((DEF_MAX + 1) / 2);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] max_val;
    logic [CNT_W-1:0] duty;
    logic [1:0]       mode;
    logic             led_run;

    assign wrap = en && (cnt == max_val);

    always_comb begin
        led_run = 1'b0;
        case (mode)
            MODE_TOGGLE: led_run = wrap ? ~led : led;
            MODE_PWM:    led_run = (cnt < duty);
            MODE_OFF:    led_run = 1'b0;
            MODE_ON:     led_run = 1'b1;
            default:     led_run = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            max_val <= RST_MAX;
            duty    <= RST_DUTY;
            mode    <= MODE_TOGGLE;
            led     <= 1'b0;
            tick    <= 1'b0;
        end else begin
            tick <= wrap;
            if (!en) begin
                cnt <= '0;
                led <= 1'b0;
            end else begin
                cnt <= wrap ? '0 : cnt + 1'b1;
                led <= led_run;
            end
            // Apply overrides the counter; a mode change also kills any pending toggle.
            if (apply) begin
                mode    <= new_mode;
                max_val <= new_max;
                duty    <= new_duty;
                cnt     <= '0;
                if (new_mode != mode) begin
                    led <= 1'b0;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/led_multi_blinker.sv
// ============================================================================
// led_multi_blinker: N-channel LED driver with a single-slot config port whose
//                    updates land on the target channel's period boundary.
//                    Revision 1.0
// ============================================================================
`default_nettype none

module led_multi_blinker
    import led_pkg::*;
#(
    parameter int CH_NUM  = 5,
    parameter int CNT_W   = 26,
    parameter int DEF_MAX = 49_999,
    localparam int CH_W   = ch_width(CH_NUM)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CH_NUM-1:0] en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [1:0]        cfg_mode,
    input  logic [CNT_W-1:0]  cfg_max,
    input  logic [CNT_W-1:0]  cfg_duty,
    output logic [CH_NUM-1:0] led,
    output logic [CH_NUM-1:0] tick
);

    logic              pending;
    logic [CH_W-1:0]   slot_ch;
    logic [1:0]        slot_mode;
    logic [CNT_W-1:0]  slot_max;
    logic [CNT_W-1:0]  slot_duty;
    logic [CH_NUM-1:0] wrap;
    logic [CH_NUM-1:0] apply;
    logic              accept;
    logic              ch_ok;

    assign cfg_ready = ~pending;
    assign accept    = cfg_valid && !pending;
    assign ch_ok     = (32'(cfg_ch) < CH_NUM);

    for (genvar i = 0; i < CH_NUM; i++) begin : g_chan
        // A disabled channel has no wrap to wait for, so it takes the update at once.
        assign apply[i] = pending && (slot_ch == CH_W'(i)) && (wrap[i] || !en[i]);

        led_chan #(
            .CNT_W   (CNT_W),
            .DEF_MAX (DEF_MAX)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .en       (en[i]),
            .apply    (apply[i]),
            .new_mode (slot_mode),
            .new_max  (slot_max),
            .new_duty (slot_duty),
            .wrap     (wrap[i]),
            .led      (led[i]),
            .tick     (tick[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending   <= 1'b0;
            slot_ch   <= '0;
            slot_mode <= MODE_TOGGLE;
            slot_max  <= '0;
            slot_duty <= '0;
        end else if (accept && ch_ok) begin
            pending   <= 1'b1;
            slot_ch   <= cfg_ch;
            slot_mode <= cfg_mode;
            slot_max  <= cfg_max;
            slot_duty <= cfg_duty;
        end else if (|apply) begin
            pending   <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_led_multi_blinker.sv
// ============================================================================
// tb_led_multi_blinker: scoreboard-checked bench for led_multi_blinker with a
//                       table of channel configurations.  Revision 1.0
// ============================================================================
`default_nettype none

module tb_led_multi_blinker;

    localparam int CH = 5;
    localparam int W  = 26;

    logic          clk;
    logic          rst;
    logic [CH-1:0] en;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [2:0]    cfg_ch;
    logic [1:0]    cfg_mode;
    logic [W-1:0]  cfg_max;
    logic [W-1:0]  cfg_duty;
    logic [CH-1:0] led;
    logic [CH-1:0] tick;

    int total = 0;
    int bad   = 0;

    led_multi_blinker #(
        .CH_NUM  (CH),
        .CNT_W   (W),
        .DEF_MAX (49_999)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_mode  (cfg_mode),
        .cfg_max   (cfg_max),
        .cfg_duty  (cfg_duty),
        .led       (led),
        .tick      (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model feeding the scoreboard ----------------
    typedef logic [2*CH:0] exp_t;
    exp_t sb[$];
    exp_t popped;

    logic [W-1:0]  m_cnt [CH];
    logic [W-1:0]  m_max [CH];
    logic [W-1:0]  m_duty[CH];
    logic [1:0]    m_mode[CH];
    logic [CH-1:0] m_led, m_tick;
    logic          m_pend, m_pend_was, m_w, m_hit;
    logic [2:0]    m_sch;
    logic [1:0]    m_smode;
    logic [W-1:0]  m_smax, m_sduty;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CH; i++) begin
                m_cnt[i]  = '0;
                m_max[i]  = 26'd49999;
                m_duty[i] = 26'd25000;
                m_mode[i] = 2'b00;
            end
            m_led  = '0;
            m_tick = '0;
            m_pend = 1'b0;
            sb.delete();
            sb.push_back({CH'(0), CH'(0), 1'b1});
        end else begin
            m_pend_was = m_pend;
            for (int i = 0; i < CH; i++) begin
                m_w   = en[i] && (m_cnt[i] == m_max[i]);
                m_hit = m_pend_was && (m_sch == 3'(i)) && (m_w || !en[i]);
                m_tick[i] = m_w;
                if (!en[i]) begin
                    m_led[i] = 1'b0;
                    m_cnt[i] = '0;
                end else begin
                    if (m_mode[i] == 2'b00)      m_led[i] = m_led[i] ^ m_w;
                    else if (m_mode[i] == 2'b01) m_led[i] = (m_cnt[i] < m_duty[i]);
                    else                         m_led[i] = m_mode[i][0];
                    m_cnt[i] = m_w ? '0 : m_cnt[i] + 26'd1;
                end
                if (m_hit) begin
                    if (m_smode != m_mode[i]) m_led[i] = 1'b0;
                    m_mode[i] = m_smode;
                    m_max[i]  = m_smax;
                    m_duty[i] = m_sduty;
                    m_cnt[i]  = '0;
                    m_pend    = 1'b0;
                end
            end
            if (cfg_valid && !m_pend_was && cfg_ch < 3'd5) begin
                m_pend  = 1'b1;
                m_sch   = cfg_ch;
                m_smode = cfg_mode;
                m_smax  = cfg_max;
                m_sduty = cfg_duty;
            end
            sb.push_back({m_led, m_tick, !m_pend});
        end
    end

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            popped = sb.pop_front();
            chk("scoreboard_led_tick_ready", 32'({led, tick, cfg_ready}), 32'(popped));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Returns at the negedge after the accepting edge.
    task automatic cfg_send(input int ch, input logic [1:0] mode, input int mx, input int duty);
        logic was_ready;
        int   n;
        cfg_valid = 1'b1;
        cfg_ch    = 3'(ch);
        cfg_mode  = mode;
        cfg_max   = W'(mx);
        cfg_duty  = W'(duty);
        n = 0;
        do begin
            was_ready = cfg_ready;
            step();
            n++;
        end while (!was_ready && n < 60000);
        if (!was_ready) chk("cfg_accept_timeout", 32'(n), 32'(0));
        cfg_valid = 1'b0;
    endtask

    typedef struct {
        int         ch;
        logic [1:0] mode;
        int         mx;
        int         duty;
        int         exp_high;
        int         exp_ticks;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int e, first_tick0, first_tick2, ready_back, hi, tk, n;

        vecs[0] = '{ch:0, mode:2'b00, mx:0, duty:0, exp_high:30, exp_ticks:60};
        vecs[1] = '{ch:1, mode:2'b01, mx:9, duty:3, exp_high:18, exp_ticks:6};
        vecs[2] = '{ch:3, mode:2'b01, mx:4, duty:0, exp_high:0,  exp_ticks:12};
        vecs[3] = '{ch:4, mode:2'b01, mx:4, duty:7, exp_high:60, exp_ticks:12};
        vecs[4] = '{ch:2, mode:2'b11, mx:2, duty:0, exp_high:60, exp_ticks:20};
        vecs[5] = '{ch:1, mode:2'b10, mx:5, duty:0, exp_high:0,  exp_ticks:10};
        vecs[6] = '{ch:3, mode:2'b00, mx:4, duty:0, exp_high:30, exp_ticks:12};

        rst = 1'b1; en = '0; cfg_valid = 1'b0; cfg_ch = '0; cfg_mode = '0;
        cfg_max = '0; cfg_duty = '0;
        repeat (3) @(negedge clk);
        chk("reset_led", 32'(led), 32'(0));
        chk("reset_tick", 32'(tick), 32'(0));
        chk("reset_ready", 32'(cfg_ready), 32'(1));
        rst = 1'b0;

        // Default periods on every channel; ch2 reprogrammed while its count is at 100.
        en = '1; e = 0; first_tick0 = 0; first_tick2 = 0; ready_back = 0;
        while (e < 50012) begin
            step(); e++;
            if (e == 100) begin
                cfg_valid = 1'b1; cfg_ch = 3'd2; cfg_mode = 2'b00;
                cfg_max = 26'd4; cfg_duty = 26'd2;
            end
            if (e == 101) begin
                chk("a_ready_drop", 32'(cfg_ready), 32'(0));
                cfg_valid = 1'b0;
            end
            if (first_tick0 == 0 && tick[0]) first_tick0 = e;
            if (ready_back == 0 && e > 101 && cfg_ready) ready_back = e;
            if (e > 50000 && first_tick2 == 0 && tick[2]) first_tick2 = e;
            if (e == 49999) chk("a_led0_before_wrap", 32'(led[0]), 32'(0));
            if (e == 50000) begin
                chk("a_led0_after_wrap", 32'(led[0]), 32'(1));
                chk("a_tick2_on_apply", 32'(tick[2]), 32'(1));
            end
        end
        chk("a_first_tick0", 32'(first_tick0), 32'(50000));
        chk("a_ready_back", 32'(ready_back), 32'(50000));
        chk("a_ch2_new_period", 32'(first_tick2), 32'(50005));

        do_reset();

        for (int k = 0; k < 7; k++) begin
            en = '0;
            step();
            cfg_send(vecs[k].ch, vecs[k].mode, vecs[k].mx, vecs[k].duty);
            chk("tbl_ready_low", 32'(cfg_ready), 32'(0));
            step();
            chk("tbl_ready_back", 32'(cfg_ready), 32'(1));
            en[vecs[k].ch] = 1'b1;
            repeat (20) step();
            hi = 0; tk = 0;
            repeat (60) begin
                step();
                hi += int'(led[vecs[k].ch]);
                tk += int'(tick[vecs[k].ch]);
            end
            chk("tbl_led_high_count", 32'(hi), 32'(vecs[k].exp_high));
            chk("tbl_tick_count", 32'(tk), 32'(vecs[k].exp_ticks));
        end

        // Out-of-range channel is swallowed without blocking the port.
        en = '1;
        repeat (3) step();
        cfg_send(7, 2'b11, 1, 1);
        chk("c_bad_ch_ready", 32'(cfg_ready), 32'(1));
        repeat (5) step();

        // Pending update on ch0 lands as soon as ch0 is disabled.
        en = '0;
        step();
        cfg_send(0, 2'b00, 19, 0);
        step();
        en = 5'b00001;
        repeat (25) step();
        chk("d_led0_on_before", 32'(led[0]), 32'(1));
        cfg_send(0, 2'b01, 9, 5);
        chk("d_pending", 32'(cfg_ready), 32'(0));
        en[0] = 1'b0;
        step();
        chk("d_led0_off", 32'(led[0]), 32'(0));
        chk("d_tick0_off", 32'(tick[0]), 32'(0));
        chk("d_applied_ready", 32'(cfg_ready), 32'(1));
        en[0] = 1'b1;
        n = 0;
        do begin step(); n++; end while (!tick[0] && n < 100);
        chk("d_first_tick_after_en", 32'(n), 32'(10));

        // Reset while an update is pending discards it.
        do_reset();
        en = 5'b01000;
        repeat (5) step();
        cfg_send(3, 2'b00, 2, 0);
        chk("e_pending", 32'(cfg_ready), 32'(0));
        #2 rst = 1'b1;
        #1;
        chk("e_async_led", 32'(led), 32'(0));
        chk("e_async_tick", 32'(tick), 32'(0));
        chk("e_async_ready", 32'(cfg_ready), 32'(1));
        @(negedge clk);
        rst = 1'b0;
        tk = 0;
        repeat (30) begin step(); tk += int'(tick[3]); end
        chk("e_update_dropped", 32'(tk), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
